// File: rtl/video_pattern_seq.sv
// Frame-synchronous pattern selector: chooses bar, solid colour, checkerboard or black each frame.
// Optional checkerboard generator enabled by defining PATTERN_SEQ_CHECKER_EN.
module video_pattern_seq #(
  parameter int HSIZE   = 11,
  parameter int VSIZE   = 11,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [HSIZE-1:0]   hc,
  input  logic [VSIZE-1:0]   vc,
  input  logic               video_on,
  input  logic [11:0]        bar_rgb,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [15:0]        wr_data,
  output logic [11:0]        rgb_out,
  output logic               video_on_out,
  output logic [1:0]         pattern_id,
  output logic               frame_tick
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_MANUAL = 2'd1,
    ST_AUTO   = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [3:0]           ctrl_shadow_reg;
  logic [11:0]          color_shadow_reg;
  logic [DWELL_W-1:0]   dwell_shadow_reg;
  logic [11:0]          color_active_reg;
  logic [DWELL_W-1:0]   dwell_cnt_reg, dwell_cnt_next;
  logic [1:0]           pattern_next;
  logic [DWELL_W-1:0]   dwell_limit;
  logic [1:0]           manual_pat;
  logic [1:0]           advance_pat;
  logic [11:0]          checker_px;
  logic [11:0]          pixel;
  state_t               eff_state;
  logic [1:0]           eff_pattern;
  logic [11:0]          eff_color;
  logic                 unused_bits;

  assign unused_bits = ^{hc, vc, wr_data};

  // DWELL of 0 behaves as 1, so the limit never underflows
  assign dwell_limit = (dwell_shadow_reg == '0) ? '0 : dwell_shadow_reg - 1'b1;

`ifdef PATTERN_SEQ_CHECKER_EN
  assign checker_px  = (hc[5] ^ vc[5]) ? 12'hFFF : 12'h000;
  assign manual_pat  = ctrl_shadow_reg[3:2];
  assign advance_pat = pattern_id + 2'd1;
`else
  assign checker_px  = 12'h000;
  assign manual_pat  = (ctrl_shadow_reg[3:2] == 2'd2) ? 2'd3 : ctrl_shadow_reg[3:2];
  always_comb begin
    case (pattern_id)
      2'd0:    advance_pat = 2'd1;
      2'd1:    advance_pat = 2'd3;
      default: advance_pat = 2'd0;
    endcase
  end
`endif

  // Commit decision, evaluated from the pre-write shadow on frame_start
  always_comb begin
    state_next     = state_reg;
    pattern_next   = pattern_id;
    dwell_cnt_next = dwell_cnt_reg;
    if (frame_start) begin
      if (!ctrl_shadow_reg[0]) begin
        state_next     = ST_OFF;
        pattern_next   = 2'd3;
        dwell_cnt_next = '0;
      end else if (!ctrl_shadow_reg[1]) begin
        state_next     = ST_MANUAL;
        pattern_next   = manual_pat;
        dwell_cnt_next = '0;
      end else begin
        state_next = ST_AUTO;
        if (state_reg != ST_AUTO) begin
          pattern_next   = 2'd0;
          dwell_cnt_next = '0;
        end else if (dwell_cnt_reg >= dwell_limit) begin
          pattern_next   = advance_pat;
          dwell_cnt_next = '0;
        end else begin
          dwell_cnt_next = dwell_cnt_reg + 1'b1;
        end
      end
    end
  end

  // Bypass so the first pixel of a frame already uses the freshly committed settings
  assign eff_state   = frame_start ? state_next : state_reg;
  assign eff_pattern = frame_start ? pattern_next : pattern_id;
  assign eff_color   = frame_start ? color_shadow_reg : color_active_reg;

  always_comb begin
    pixel = 12'h000;
    if (video_on && (eff_state != ST_OFF)) begin
      case (eff_pattern)
        2'd0:    pixel = bar_rgb;
        2'd1:    pixel = eff_color;
        2'd2:    pixel = checker_px;
        default: pixel = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_OFF;
      ctrl_shadow_reg  <= '0;
      color_shadow_reg <= '0;
      dwell_shadow_reg <= '0;
      color_active_reg <= '0;
      dwell_cnt_reg    <= '0;
      pattern_id       <= 2'd3;
      rgb_out          <= '0;
      video_on_out     <= 1'b0;
      frame_tick       <= 1'b0;
    end else begin
      rgb_out      <= pixel;
      video_on_out <= video_on;
      frame_tick   <= frame_start;
      if (frame_start) begin
        state_reg        <= state_next;
        pattern_id       <= pattern_next;
        dwell_cnt_reg    <= dwell_cnt_next;
        color_active_reg <= color_shadow_reg;
      end
      if (wr_en) begin
        case (wr_addr)
          2'd0:    ctrl_shadow_reg  <= wr_data[3:0];
          2'd1:    color_shadow_reg <= wr_data[11:0];
          2'd2:    dwell_shadow_reg <= wr_data[DWELL_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_seq.sv
// Directed self-checking bench for video_pattern_seq.
module tb_video_pattern_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [10:0] hc = '0;
  logic [10:0] vc = '0;
  logic        video_on = 1'b0;
  logic [11:0] bar_rgb = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [11:0] rgb_out;
  logic        video_on_out;
  logic [1:0]  pattern_id;
  logic        frame_tick;

  int vectors = 0;
  int miscompares = 0;

  video_pattern_seq #(.HSIZE(11), .VSIZE(11), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .hc(hc), .vc(vc),
    .video_on(video_on), .bar_rgb(bar_rgb), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rgb_out(rgb_out), .video_on_out(video_on_out),
    .pattern_id(pattern_id), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // One clock with the given inputs; returns 1 time unit after the edge
  task automatic step(input logic fs, input logic [10:0] h, input logic [10:0] v,
                      input logic von, input logic [11:0] bar,
                      input logic we, input logic [1:0] wa, input logic [15:0] wd);
    frame_start = fs; hc = h; vc = v; video_on = von; bar_rgb = bar;
    wr_en = we; wr_addr = wa; wr_data = wd;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic chk_rgb(input string name, input logic [11:0] exp);
    vectors++;
    if (rgb_out !== exp) begin
      miscompares++;
      $display("FAIL %s: rgb_out=%h expected %h", name, rgb_out, exp);
    end else $display("ok   %s: rgb_out=%h", name, rgb_out);
  endtask

  task automatic chk_pid(input string name, input logic [1:0] exp);
    vectors++;
    if (pattern_id !== exp) begin
      miscompares++;
      $display("FAIL %s: pattern_id=%0d expected %0d", name, pattern_id, exp);
    end else $display("ok   %s: pattern_id=%0d", name, pattern_id);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    chk_rgb("reset_rgb", 12'h000);
    chk_pid("reset_pid", 2'd3);
    vectors++;
    if (video_on_out !== 1'b0 || frame_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: von_out=%b tick=%b expected 0 0", video_on_out, frame_tick);
    end else $display("ok   reset_flags");
    rst_n = 1'b1;
    step(1, 0, 0, 1, 12'hABC, 0, 0, 0);
    chk_rgb("off_after_reset_rgb", 12'h000);
    chk_pid("off_after_reset_pid", 2'd3);
    vectors++;
    if (frame_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL off_tick: frame_tick=%b expected 1", frame_tick);
    end else $display("ok   off_tick");
  endtask

  task automatic test_manual_bar;
    step(0, 0, 0, 1, 12'h111, 1, 2'd0, 16'h0001);
    chk_rgb("bar_write_no_effect", 12'h000);
    chk_pid("bar_write_pid", 2'd3);
    step(1, 0, 0, 1, 12'h123, 0, 0, 0);
    chk_rgb("bar_first_pixel", 12'h123);
    chk_pid("bar_pid", 2'd0);
    step(0, 1, 0, 1, 12'h456, 0, 0, 0);
    chk_rgb("bar_second_pixel", 12'h456);
    vectors++;
    if (frame_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL bar_tick_clear: frame_tick=%b expected 0", frame_tick);
    end else $display("ok   bar_tick_clear");
    step(0, 2, 0, 0, 12'h789, 0, 0, 0);
    chk_rgb("bar_blanked", 12'h000);
    vectors++;
    if (video_on_out !== 1'b0) begin
      miscompares++;
      $display("FAIL bar_von_out: video_on_out=%b expected 0", video_on_out);
    end else $display("ok   bar_von_out");
  endtask

  task automatic test_staged_color;
    step(0, 0, 0, 1, 12'h111, 1, 2'd1, 16'h00A5);
    chk_rgb("color_wr_bar_still", 12'h111);
    step(0, 0, 0, 1, 12'h222, 1, 2'd0, 16'h0005);
    chk_rgb("ctrl_wr_bar_still", 12'h222);
    step(1, 0, 0, 1, 12'h333, 0, 0, 0);
    chk_rgb("color_commit", 12'h0A5);
    chk_pid("color_pid", 2'd1);
    step(0, 1, 0, 1, 12'h333, 1, 2'd1, 16'h0F00);
    chk_rgb("color_midframe_write", 12'h0A5);
    step(0, 2, 0, 1, 12'h333, 0, 0, 0);
    chk_rgb("color_midframe_hold", 12'h0A5);
    step(1, 0, 0, 1, 12'h333, 0, 0, 0);
    chk_rgb("color_next_frame", 12'hF00);
    step(1, 0, 0, 1, 12'h333, 1, 2'd1, 16'h000F);
    chk_rgb("color_coincident_write", 12'hF00);
    step(0, 1, 0, 1, 12'h333, 0, 0, 0);
    chk_rgb("color_coincident_hold", 12'hF00);
    step(1, 0, 0, 1, 12'h333, 0, 0, 0);
    chk_rgb("color_coincident_late", 12'h00F);
    step(0, 0, 0, 1, 12'h333, 1, 2'd3, 16'h0001);
    chk_rgb("addr3_ignored", 12'h00F);
  endtask

  task automatic test_auto;
    logic [1:0] seq [12];
`ifdef PATTERN_SEQ_CHECKER_EN
    seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
`else
    seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
`endif
    step(0, 0, 0, 1, 12'h321, 1, 2'd2, 16'h0002);
    step(0, 0, 0, 1, 12'h321, 1, 2'd0, 16'h0003);
    for (int i = 0; i < 12; i++) begin
      logic [11:0] exp_rgb;
      if (i == 9) step(0, 0, 0, 1, 12'h321, 1, 2'd2, 16'h0000);
      step(1, 0, 0, 1, 12'h321, 0, 0, 0);
      case (seq[i])
        2'd0:    exp_rgb = 12'h321;
        2'd1:    exp_rgb = 12'h00F;
        default: exp_rgb = 12'h000;
      endcase
      chk_pid($sformatf("auto_pid_%0d", i), seq[i]);
      chk_rgb($sformatf("auto_rgb_%0d", i), exp_rgb);
    end
  endtask

  task automatic test_checker;
    logic [11:0] white;
    logic [1:0]  pid2;
`ifdef PATTERN_SEQ_CHECKER_EN
    white = 12'hFFF; pid2 = 2'd2;
`else
    white = 12'h000; pid2 = 2'd3;
`endif
    step(0, 0, 0, 1, 12'h321, 1, 2'd0, 16'h0009);
    step(1, 11'd32, 0, 1, 12'h321, 0, 0, 0);
    chk_pid("checker_pid", pid2);
    chk_rgb("checker_32_0", white);
    step(0, 11'd32, 11'd32, 1, 12'h321, 0, 0, 0);
    chk_rgb("checker_32_32", 12'h000);
    step(0, 11'd0, 11'd32, 1, 12'h321, 0, 0, 0);
    chk_rgb("checker_0_32", white);
  endtask

  task automatic test_disable;
    step(0, 0, 0, 1, 12'h555, 1, 2'd0, 16'h0003);
    step(1, 0, 0, 1, 12'h555, 0, 0, 0);
    chk_pid("dis_auto_entry", 2'd0);
    chk_rgb("dis_auto_entry_rgb", 12'h555);
    step(1, 0, 0, 1, 12'h555, 0, 0, 0);
    chk_pid("dis_auto_adv", 2'd1);
    step(0, 0, 0, 1, 12'h555, 1, 2'd0, 16'h0000);
    step(1, 0, 0, 1, 12'h555, 0, 0, 0);
    chk_pid("dis_off_pid", 2'd3);
    chk_rgb("dis_off_rgb", 12'h000);
    step(0, 0, 0, 1, 12'h555, 1, 2'd2, 16'h0002);
    step(0, 0, 0, 1, 12'h555, 1, 2'd0, 16'h0003);
    step(1, 0, 0, 1, 12'h555, 0, 0, 0);
    chk_pid("reen_pid_0", 2'd0);
    chk_rgb("reen_rgb_0", 12'h555);
    step(1, 0, 0, 1, 12'h555, 0, 0, 0);
    chk_pid("reen_pid_1", 2'd0);
    step(1, 0, 0, 1, 12'h555, 0, 0, 0);
    chk_pid("reen_pid_2", 2'd1);
  endtask

  task automatic test_async_reset;
    step(0, 5, 5, 1, 12'h555, 0, 0, 0);
    chk_rgb("pre_reset_rgb", 12'h00F);
    #3;
    rst_n = 1'b0;
    #1;
    chk_rgb("async_reset_rgb", 12'h000);
    chk_pid("async_reset_pid", 2'd3);
    vectors++;
    if (video_on_out !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_von: video_on_out=%b expected 0", video_on_out);
    end else $display("ok   async_reset_von");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 1, 12'h555, 0, 0, 0);
    chk_rgb("post_reset_idle", 12'h000);
    step(1, 0, 0, 1, 12'h555, 0, 0, 0);
    chk_pid("post_reset_fs_pid", 2'd3);
    chk_rgb("post_reset_fs_rgb", 12'h000);
  endtask

  initial begin
    test_reset();
    test_manual_bar();
    test_staged_color();
    test_auto();
    test_checker();
    test_disable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
